mm_refill_arbiter: RTL and testbench

Refill controller and arbiter for the single main-memory read port, shared by the direct-mapped instruction cache and the data cache.
- Accepts miss requests from both caches and grants the port round-robin.
- Issues one word read per grant, with a retry if memory times out.
- Returns the word with a one-cycle done pulse; that pulse drives the cache's memory-access/refill-write input.
- Keeps refill, retry and stall counters for performance checking.

---
 rtl/mm_refill_arbiter.sv | 123 ++++++++++++
 tb/tb_mm_refill_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mm_refill_arbiter.sv
// mm_refill_arbiter: round-robin refill arbiter for the shared main-memory read port (I-cache / D-cache)
// Ports: CLK/RESET (sync, active-high); I_REQ/I_ADDR, D_REQ/D_ADDR miss requests;
// MM_RD/MM_ADDR read issue, MM_RDATA/MM_RVALID read return; I_DONE/I_DATA, D_DONE/D_DATA refill results;
// BUSY, GNT_D status; CNT_* saturating refill/retry/stall statistics.
module mm_refill_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 20
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             I_REQ,
  input  logic [31:0]      I_ADDR,
  input  logic             D_REQ,
  input  logic [31:0]      D_ADDR,
  output logic             MM_RD,
  output logic [31:0]      MM_ADDR,
  input  logic [31:0]      MM_RDATA,
  input  logic             MM_RVALID,
  output logic             I_DONE,
  output logic [31:0]      I_DATA,
  output logic             D_DONE,
  output logic [31:0]      D_DATA,
  output logic             BUSY,
  output logic             GNT_D,
  output logic [CNT_W-1:0] CNT_I_REFILL,
  output logic [CNT_W-1:0] CNT_D_REFILL,
  output logic [CNT_W-1:0] CNT_RETRY,
  output logic [CNT_W-1:0] CNT_STALL
);
  localparam int WW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t           state_q, state_d;
  logic             gnt_d_q, gnt_d_d, last_q, last_d, pick_d, retry;
  logic [31:0]      addr_q, addr_d, i_data_q, i_data_d, d_data_q, d_data_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] cnt_i_q, cnt_i_d, cnt_d_q, cnt_d_d, cnt_r_q, cnt_r_d, cnt_s_q, cnt_s_d;
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c, input logic en);
    return c + CNT_W'(en && !(&c));
  endfunction
  // on a tie the requester that was not served last wins
  assign pick_d = D_REQ && (!I_REQ || !last_q);
  always_comb begin
    state_d  = state_q;
    gnt_d_d  = gnt_d_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wait_d   = wait_q;
    i_data_d = i_data_q;
    d_data_d = d_data_q;
    retry    = 1'b0;
    case (state_q)
      IDLE: if (I_REQ || D_REQ) begin
        state_d = ISSUE;
        gnt_d_d = pick_d;
        addr_d  = (pick_d ? D_ADDR : I_ADDR) & 32'hFFFF_FFFC;
      end
      ISSUE: begin
        state_d = WAIT;
        wait_d  = '0;
      end
      WAIT: begin
        wait_d = wait_q + WW'(1);
        // returning data beats a coincident timeout
        if (MM_RVALID) begin
          state_d  = RESP;
          i_data_d = gnt_d_q ? i_data_q : MM_RDATA;
          d_data_d = gnt_d_q ? MM_RDATA : d_data_q;
        end else if (wait_q == WW'(TIMEOUT - 1)) begin
          state_d = ISSUE;
          retry   = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        last_d  = gnt_d_q;
      end
      default: state_d = IDLE;
    endcase
    cnt_i_d = sat(cnt_i_q, state_q == RESP && !gnt_d_q);
    cnt_d_d = sat(cnt_d_q, state_q == RESP && gnt_d_q);
    cnt_r_d = sat(cnt_r_q, retry);
    cnt_s_d = sat(cnt_s_q, state_q != IDLE);
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      gnt_d_q  <= 1'b0;
      last_q   <= 1'b0;
      addr_q   <= '0;
      wait_q   <= '0;
      i_data_q <= '0;
      d_data_q <= '0;
      cnt_i_q  <= '0;
      cnt_d_q  <= '0;
      cnt_r_q  <= '0;
      cnt_s_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_d_q  <= gnt_d_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wait_q   <= wait_d;
      i_data_q <= i_data_d;
      d_data_q <= d_data_d;
      cnt_i_q  <= cnt_i_d;
      cnt_d_q  <= cnt_d_d;
      cnt_r_q  <= cnt_r_d;
      cnt_s_q  <= cnt_s_d;
    end
  end
  assign MM_RD        = state_q == ISSUE;
  assign MM_ADDR      = addr_q;
  assign I_DONE       = state_q == RESP && !gnt_d_q;
  assign D_DONE       = state_q == RESP && gnt_d_q;
  assign I_DATA       = i_data_q;
  assign D_DATA       = d_data_q;
  assign BUSY         = state_q != IDLE;
  assign GNT_D        = gnt_d_q;
  assign CNT_I_REFILL = cnt_i_q;
  assign CNT_D_REFILL = cnt_d_q;
  assign CNT_RETRY    = cnt_r_q;
  assign CNT_STALL    = cnt_s_q;
endmodule

// File: tb/tb_mm_refill_arbiter.sv
// tb_mm_refill_arbiter: directed vector bench for mm_refill_arbiter
module tb_mm_refill_arbiter;
  logic        clk = 1'b0, rst, i_req, d_req, mm_rd, mm_rvalid, i_done, d_done, busy, gnt_d;
  logic [31:0] i_addr, d_addr, mm_addr, mm_rdata, i_data, d_data;
  logic [19:0] cnt_i, cnt_d, cnt_r, cnt_s;
  int          nchk = 0, nerr = 0;
  bit          ok;
  always #5 clk = ~clk;
  mm_refill_arbiter dut (
    .CLK(clk), .RESET(rst), .I_REQ(i_req), .I_ADDR(i_addr), .D_REQ(d_req), .D_ADDR(d_addr),
    .MM_RD(mm_rd), .MM_ADDR(mm_addr), .MM_RDATA(mm_rdata), .MM_RVALID(mm_rvalid),
    .I_DONE(i_done), .I_DATA(i_data), .D_DONE(d_done), .D_DATA(d_data), .BUSY(busy), .GNT_D(gnt_d),
    .CNT_I_REFILL(cnt_i), .CNT_D_REFILL(cnt_d), .CNT_RETRY(cnt_r), .CNT_STALL(cnt_s)
  );
  typedef struct {
    logic rst, ir; logic [31:0] ia; logic dr; logic [31:0] da; logic rv; logic [31:0] rdat;
    logic e_rd; logic [31:0] e_addr; logic e_idone, e_ddone, e_busy, e_gnt;
    logic [31:0] e_idata, e_ddata, e_ci, e_cd, e_cs;
  } vec_t;
  vec_t tbl [18];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic wait_rd(output bit found);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mm_rd) found = 1'b1;
      else step();
    end
    chk("mm_rd_seen", 32'(found), 32'd1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0]  = '{1,1,0,0,0,1,32'h1,                 0,0,0,0,0,0,0,0,0,0,0};
    tbl[1]  = '{1,0,0,1,0,0,0,                     0,0,0,0,0,0,0,0,0,0,0};
    tbl[2]  = '{0,1,32'h00401237,0,0,1,32'hBAD0BAD0, 1,32'h00401234,0,0,1,0,0,0,0,0,0};
    tbl[3]  = '{0,1,32'hFFFFFFFF,0,0,1,32'hBAD1BAD1, 0,32'h00401234,0,0,1,0,0,0,0,0,1};
    tbl[4]  = '{0,1,32'hFFFFFFFF,0,0,0,0,            0,32'h00401234,0,0,1,0,0,0,0,0,2};
    tbl[5]  = '{0,1,32'hFFFFFFFF,0,0,0,0,            0,32'h00401234,0,0,1,0,0,0,0,0,3};
    tbl[6]  = '{0,1,32'hFFFFFFFF,0,0,0,0,            0,32'h00401234,0,0,1,0,0,0,0,0,4};
    tbl[7]  = '{0,1,32'hFFFFFFFF,0,0,1,32'hDEADBEEF, 0,32'h00401234,1,0,1,0,32'hDEADBEEF,0,0,0,5};
    tbl[8]  = '{0,0,0,0,0,1,32'h11111111,            0,32'h00401234,0,0,0,0,32'hDEADBEEF,0,1,0,6};
    tbl[9]  = '{1,1,0,1,0,0,0,                       0,0,0,0,0,0,0,0,0,0,0};
    tbl[10] = '{0,1,32'h00000100,1,32'h00002002,0,0, 1,32'h00002000,0,0,1,1,0,0,0,0,0};
    tbl[11] = '{0,1,32'h00000100,1,32'h00002002,0,0, 0,32'h00002000,0,0,1,1,0,0,0,0,1};
    tbl[12] = '{0,1,32'h00000100,1,32'h00002002,1,32'hCAFEF00D, 0,32'h00002000,0,1,1,1,0,32'hCAFEF00D,0,0,2};
    tbl[13] = '{0,1,32'h00000100,0,0,0,0,            0,32'h00002000,0,0,0,1,0,32'hCAFEF00D,0,1,3};
    tbl[14] = '{0,1,32'h00000100,0,0,0,0,            1,32'h00000100,0,0,1,0,0,32'hCAFEF00D,0,1,3};
    tbl[15] = '{0,1,32'h00000100,0,0,1,32'h12345678, 0,32'h00000100,0,0,1,0,0,32'hCAFEF00D,0,1,4};
    tbl[16] = '{0,1,32'h00000100,0,0,1,32'h0000ABCD, 0,32'h00000100,1,0,1,0,32'h0000ABCD,32'hCAFEF00D,0,1,5};
    tbl[17] = '{0,0,0,0,0,0,0,                       0,32'h00000100,0,0,0,0,32'h0000ABCD,32'hCAFEF00D,1,1,6};
    rst = 1; i_req = 0; d_req = 0; i_addr = 0; d_addr = 0; mm_rvalid = 0; mm_rdata = 0;
    #1;
    for (int k = 0; k < 18; k++) begin
      rst = tbl[k].rst; i_req = tbl[k].ir; i_addr = tbl[k].ia; d_req = tbl[k].dr;
      d_addr = tbl[k].da; mm_rvalid = tbl[k].rv; mm_rdata = tbl[k].rdat;
      step();
      chk($sformatf("v%0d mm_rd", k), 32'(mm_rd), 32'(tbl[k].e_rd));
      chk($sformatf("v%0d mm_addr", k), mm_addr, tbl[k].e_addr);
      chk($sformatf("v%0d i_done", k), 32'(i_done), 32'(tbl[k].e_idone));
      chk($sformatf("v%0d d_done", k), 32'(d_done), 32'(tbl[k].e_ddone));
      chk($sformatf("v%0d busy", k), 32'(busy), 32'(tbl[k].e_busy));
      chk($sformatf("v%0d gnt_d", k), 32'(gnt_d), 32'(tbl[k].e_gnt));
      chk($sformatf("v%0d i_data", k), i_data, tbl[k].e_idata);
      chk($sformatf("v%0d d_data", k), d_data, tbl[k].e_ddata);
      chk($sformatf("v%0d cnt_i", k), 32'(cnt_i), tbl[k].e_ci);
      chk($sformatf("v%0d cnt_d", k), 32'(cnt_d), tbl[k].e_cd);
      chk($sformatf("v%0d cnt_s", k), 32'(cnt_s), tbl[k].e_cs);
      chk($sformatf("v%0d cnt_r", k), 32'(cnt_r), 32'd0);
    end
    // fairness: both requesters held for six transactions
    rst = 1; mm_rvalid = 0; step();
    rst = 0; i_req = 1; d_req = 1; i_addr = 32'h1000; d_addr = 32'h2000; step();
    for (int k = 0; k < 6; k++) begin
      wait_rd(ok);
      chk($sformatf("fair%0d gnt_d", k), 32'(gnt_d), 32'((k % 2) == 0));
      step();
      mm_rvalid = 1; mm_rdata = 32'(k); step();
      mm_rvalid = 0;
      chk($sformatf("fair%0d done", k), {30'b0, i_done, d_done}, (k % 2) == 0 ? 32'd1 : 32'd2);
      if (k == 5) begin i_req = 0; d_req = 0; end
      step();
    end
    chk("fair cnt_i", 32'(cnt_i), 32'd3);
    chk("fair cnt_d", 32'(cnt_d), 32'd3);
    chk("fair i_data", i_data, 32'd5);
    chk("fair d_data", d_data, 32'd4);
    // timeout and re-issue with the same address
    rst = 1; step();
    rst = 0; i_req = 1; i_addr = 32'h8000_0013; step();
    chk("to first addr", mm_addr, 32'h8000_0010);
    begin
      int n = 1;
      step();
      while (!mm_rd && n < 200) begin step(); n++; end
      chk("to reissue cycles", 32'(n), 32'd65);
    end
    chk("to reissue addr", mm_addr, 32'h8000_0010);
    chk("to cnt_r", 32'(cnt_r), 32'd1);
    step();
    mm_rvalid = 1; mm_rdata = 32'h5A5A5A5A; step();
    mm_rvalid = 0;
    chk("to i_done", 32'(i_done), 32'd1);
    chk("to i_data", i_data, 32'h5A5A5A5A);
    i_req = 0; step();
    chk("to cnt_i", 32'(cnt_i), 32'd1);
    // data and timeout coinciding: data wins, no retry
    i_req = 1; i_addr = 32'h8000_0020; step();
    repeat (64) step();
    chk("coin still waiting", 32'(mm_rd), 32'd0);
    mm_rvalid = 1; mm_rdata = 32'h0BADF00D; step();
    mm_rvalid = 0;
    chk("coin i_done", 32'(i_done), 32'd1);
    chk("coin i_data", i_data, 32'h0BADF00D);
    chk("coin cnt_r", 32'(cnt_r), 32'd1);
    i_req = 0; step();
    // reset in WAIT, stale MM_RVALID afterwards
    i_req = 1; i_addr = 32'h40; step(); step(); step();
    chk("rw in wait", 32'(busy), 32'd1);
    rst = 1; i_req = 0; step();
    rst = 0; mm_rvalid = 1; mm_rdata = 32'hFFFF0000; step();
    mm_rvalid = 0;
    chk("rw i_done", 32'(i_done), 32'd0);
    chk("rw busy", 32'(busy), 32'd0);
    chk("rw mm_rd", 32'(mm_rd), 32'd0);
    chk("rw i_data", i_data, 32'd0);
    chk("rw cnt_i", 32'(cnt_i), 32'd0);
    chk("rw cnt_r", 32'(cnt_r), 32'd0);
    chk("rw cnt_s", 32'(cnt_s), 32'd0);
    chk("rw mm_addr", mm_addr, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
